// File: rtl/prg_loader_if.sv
// Bundle of HPS ioctl download signals and PET RAM DMA write port for prg_loader.
// The loader connects to the slave modport; whatever feeds files and owns RAM uses master.
interface prg_loader_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [14:0] dma_addr;
   logic [7:0]  dma_dout;
   logic        dma_we;
   logic        dma_rdy;
   logic        busy;
   logic        overflow;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_rdy,
      output ioctl_wait, dma_addr, dma_dout, dma_we, busy, overflow
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_rdy,
      input  ioctl_wait, dma_addr, dma_dout, dma_we, busy, overflow
   );
endinterface

// File: rtl/prg_loader.sv
// Streams a .PRG download (2-byte load address header + data) into PET RAM over a
// stalling DMA write port, then optionally patches the BASIC end-of-program pointers.
module prg_loader #(
   parameter logic [7:0]  INDEX   = 8'h41,
   parameter logic [14:0] RAM_TOP = 15'h7FFF,
   parameter bit          FIXUP   = 1'b1
) (
   input logic         clk,
   input logic         reset_n,
   prg_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_FIXUP, S_DONE
   } state_t;

   localparam logic [15:0] TOP16    = {1'b0, RAM_TOP};
   localparam logic [15:0] END_CAP  = TOP16 + 16'd1;
   localparam logic [14:0] PTR_BASE = 15'h002A;

   state_t      state;
   logic        start_q;
   logic [7:0]  load_lo;
   logic [15:0] cur_addr;
   logic        wrapped;
   logic        skip;
   logic        wait_q;
   logic [2:0]  fix_idx;

   logic        idx_ok;
   logic        wr_ok;
   logic        start_cond;
   logic        data_stb;
   logic        in_range;
   logic [15:0] fix_end;
   state_t      end_state;

   assign idx_ok     = (bus.ioctl_index == INDEX);
   assign wr_ok      = bus.ioctl_wr & idx_ok;
   assign start_cond = bus.ioctl_download & idx_ok;
   assign data_stb   = (state == S_DATA) && bus.ioctl_download && wr_ok && (bus.ioctl_addr > 25'd1);
   assign in_range   = !wrapped && (cur_addr <= TOP16);
   assign fix_end    = (cur_addr > END_CAP) ? END_CAP : cur_addr;
   assign end_state  = FIXUP ? S_FIXUP : S_DONE;

   // The stall must reach the HPS in the very cycle the byte is strobed, so the
   // registered hold is ORed with the live strobe decode.
   assign bus.ioctl_wait = wait_q | data_stb;
   assign bus.busy       = (state != S_IDLE);

   // NOTE: every register here is assigned with <= so all updates land together at the
   // clock edge; a blocking = would let later lines see half-updated state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         start_q      <= 1'b1;  // a download already high at release is not a new start
         load_lo      <= '0;
         cur_addr     <= '0;
         wrapped      <= 1'b0;
         skip         <= 1'b0;
         wait_q       <= 1'b0;
         fix_idx      <= '0;
         bus.dma_addr <= '0;
         bus.dma_dout <= '0;
         bus.dma_we   <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         start_q <= start_cond;
         case (state)
            S_IDLE: begin
               if (start_cond && !start_q) begin
                  state        <= S_HDR_LO;
                  bus.overflow <= 1'b0;
                  cur_addr     <= '0;
                  wrapped      <= 1'b0;
                  fix_idx      <= '0;
               end
            end
            S_HDR_LO: begin
               if (!bus.ioctl_download) begin
                  state <= S_DONE;
               end else if (wr_ok && bus.ioctl_addr == 25'd0) begin
                  load_lo <= bus.ioctl_dout;
                  state   <= S_HDR_HI;
               end
            end
            S_HDR_HI: begin
               if (!bus.ioctl_download) begin
                  state <= S_DONE;
               end else if (wr_ok && bus.ioctl_addr == 25'd1) begin
                  cur_addr <= {bus.ioctl_dout, load_lo};
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (!bus.ioctl_download) begin
                  state <= end_state;
               end else if (data_stb) begin
                  wait_q <= 1'b1;
                  skip   <= !in_range;
                  state  <= S_WRITE;
                  if (in_range) begin
                     bus.dma_we   <= 1'b1;
                     bus.dma_addr <= cur_addr[14:0];
                     bus.dma_dout <= bus.ioctl_dout;
                  end else begin
                     bus.overflow <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               // A dropped byte spends exactly one cycle here with no write request.
               if (skip || bus.dma_rdy) begin
                  bus.dma_we <= 1'b0;
                  wait_q     <= 1'b0;
                  cur_addr   <= cur_addr + 16'd1;
                  if (cur_addr == 16'hFFFF) wrapped <= 1'b1;
                  state <= bus.ioctl_download ? S_DATA : end_state;
               end
            end
            S_FIXUP: begin
               if (!bus.dma_we) begin
                  bus.dma_we   <= 1'b1;
                  bus.dma_addr <= PTR_BASE + 15'(fix_idx);
                  bus.dma_dout <= fix_idx[0] ? fix_end[15:8] : fix_end[7:0];
               end else if (bus.dma_rdy) begin
                  bus.dma_we <= 1'b0;
                  if (fix_idx == 3'd5) state <= S_DONE;
                  else                 fix_idx <= fix_idx + 3'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prg_loader.sv
// Directed and randomized PRG loads against a byte-list reference model of the loader.
module tb_prg_loader;
   localparam logic [7:0] IDX = 8'h41;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   prg_loader_if dif();

   prg_loader dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (dif.slave)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int rdy_mode    = 0;  // 0 always ready, 1 five-cycle stall, 2 random, 3 never ready

   logic [22:0] obs_q[$];
   logic [22:0] exp_q[$];
   logic [7:0]  data_q[$];
   logic        exp_ovf;
   logic        in_load = 1'b0;

   int          unstable  = 0;
   int          we_idle   = 0;
   int          wait_drop = 0;
   logic        hold_q    = 1'b0;
   logic [22:0] hold_v    = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RAM-side model of dma_rdy; an accept is remembered so a stall restarts per byte.
   initial begin : rdy_drv
      int   wcnt;
      logic pwe;
      logic prdy;
      wcnt = 0; pwe = 1'b0; prdy = 1'b0;
      dif.dma_rdy = 1'b0;
      forever begin
         tick();
         if (pwe && prdy) wcnt = 0;
         case (rdy_mode)
            0: dif.dma_rdy = 1'b1;
            1: begin
               if (!dif.dma_we)   begin wcnt = 0; dif.dma_rdy = 1'b0; end
               else if (wcnt < 5) begin wcnt++;   dif.dma_rdy = 1'b0; end
               else               dif.dma_rdy = 1'b1;
            end
            2: dif.dma_rdy = ($urandom_range(0, 2) != 0);
            default: dif.dma_rdy = 1'b0;
         endcase
         pwe  = dif.dma_we;
         prdy = dif.dma_rdy;
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (dif.dma_we && dif.dma_rdy) obs_q.push_back({dif.dma_addr, dif.dma_dout});
         if (hold_q && (!dif.dma_we || {dif.dma_addr, dif.dma_dout} != hold_v)) unstable <= unstable + 1;
         if (dif.dma_we && !dif.busy) we_idle <= we_idle + 1;
         if (in_load && dif.dma_we && !dif.ioctl_wait) wait_drop <= wait_drop + 1;
         hold_q <= dif.dma_we && !dif.dma_rdy;
         hold_v <= {dif.dma_addr, dif.dma_dout};
      end else begin
         hold_q <= 1'b0;
      end
   end

   // Reference: each data byte lands at load+i unless above 7FFF or past a 16-bit wrap;
   // with a full header the six pointer bytes carry min(final address, 8000).
   function automatic void build_expected(input logic [15:0] la, input int hdr_n);
      logic [15:0] cur;
      logic [15:0] fend;
      bit          wrapped;
      exp_q.delete();
      exp_ovf = 1'b0;
      if (hdr_n < 2) return;
      cur = la;
      wrapped = 0;
      foreach (data_q[i]) begin
         if (!wrapped && cur < 16'h8000) exp_q.push_back({cur[14:0], data_q[i]});
         else exp_ovf = 1'b1;
         if (cur == 16'hFFFF) wrapped = 1;
         cur = cur + 16'd1;
      end
      fend = (cur < 16'h8000) ? cur : 16'h8000;
      for (int k = 0; k < 6; k++)
         exp_q.push_back({15'h002A + 15'(k), (k % 2 == 1) ? fend[15:8] : fend[7:0]});
   endfunction

   task automatic wait_release();
      int n;
      n = 0;
      while (dif.ioctl_wait && n < 300) begin tick(); n++; end
      check("wait_release", 32'(dif.ioctl_wait), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (dif.busy && n < 500) begin tick(); n++; end
      check("back_to_idle", 32'(dif.busy), 32'd0);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit is_data, input bit no_wait);
      dif.ioctl_wr   = 1'b1;
      dif.ioctl_addr = a;
      dif.ioctl_dout = d;
      @(negedge clk);
      if (is_data) check("wait_on_strobe", 32'(dif.ioctl_wait), 32'd1);
      tick();
      dif.ioctl_wr = 1'b0;
      if (!no_wait) wait_release();
   endtask

   task automatic stray_strobe(input logic [24:0] a);
      dif.ioctl_index = 8'h01;
      dif.ioctl_wr    = 1'b1;
      dif.ioctl_addr  = a;
      dif.ioctl_dout  = 8'hEE;
      @(negedge clk);
      check("stray_no_wait", 32'(dif.ioctl_wait), 32'd0);
      tick();
      dif.ioctl_wr    = 1'b0;
      dif.ioctl_index = IDX;
   endtask

   task automatic run_load(input logic [15:0] la, input int hdr_n, input bit early_drop, input bit stray);
      obs_q.delete();
      build_expected(la, hdr_n);
      dif.ioctl_index    = IDX;
      dif.ioctl_download = 1'b1;
      tick();
      tick();
      check("busy_at_start", 32'(dif.busy), 32'd1);
      check("ovf_cleared", 32'(dif.overflow), 32'd0);
      if (hdr_n > 0) send_byte(25'd0, la[7:0], 1'b0, 1'b0);
      if (hdr_n > 1) begin
         send_byte(25'd1, la[15:8], 1'b0, 1'b0);
         in_load = 1'b1;
         foreach (data_q[i]) begin
            if (stray) stray_strobe(25'(i + 2));
            if (early_drop && i == data_q.size() - 1) begin
               send_byte(25'(i + 2), data_q[i], 1'b1, 1'b1);
               in_load = 1'b0;
               dif.ioctl_download = 1'b0;
            end else begin
               send_byte(25'(i + 2), data_q[i], 1'b1, 1'b0);
            end
         end
      end
      in_load = 1'b0;
      dif.ioctl_download = 1'b0;
      wait_idle();
      check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i])
         if (i < obs_q.size()) check($sformatf("write[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));
      check("overflow", 32'(dif.overflow), 32'(exp_ovf));
      check("wait_low_idle", 32'(dif.ioctl_wait), 32'd0);
      tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      dif.ioctl_download = 1'b0;
      dif.ioctl_index    = IDX;
      dif.ioctl_wr       = 1'b0;
      dif.ioctl_addr     = '0;
      dif.ioctl_dout     = '0;

      // Reset values
      #1 reset_n = 1'b0;
      #1;
      check("rst_busy",     32'(dif.busy),       32'd0);
      check("rst_we",       32'(dif.dma_we),     32'd0);
      check("rst_wait",     32'(dif.ioctl_wait), 32'd0);
      check("rst_addr",     32'(dif.dma_addr),   32'd0);
      check("rst_dout",     32'(dif.dma_dout),   32'd0);
      check("rst_overflow", 32'(dif.overflow),   32'd0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();

      // Basic load, then the same load under a five-cycle RAM stall per byte
      data_q = '{8'hAA, 8'hBB};
      rdy_mode = 0; run_load(16'h0401, 2, 1'b0, 1'b0);
      rdy_mode = 1; run_load(16'h0401, 2, 1'b0, 1'b0);
      // Download dropped while the final write is still stalled
      run_load(16'h0401, 2, 1'b1, 1'b0);

      // Crossing RAM_TOP drops the tail byte
      rdy_mode = 0;
      data_q = '{8'h11, 8'h22, 8'h33};
      run_load(16'h7FFE, 2, 1'b0, 1'b0);

      // 16-bit address wrap: nothing may be written after it
      run_load(16'hFFFE, 2, 1'b0, 1'b0);

      // Foreign file index: loader must stay inert
      obs_q.delete();
      dif.ioctl_index    = 8'h01;
      dif.ioctl_download = 1'b1;
      tick();
      send_byte(25'd0, 8'h01, 1'b0, 1'b1);
      send_byte(25'd1, 8'h04, 1'b0, 1'b1);
      send_byte(25'd2, 8'hAA, 1'b0, 1'b1);
      check("foreign_busy", 32'(dif.busy), 32'd0);
      check("foreign_wait", 32'(dif.ioctl_wait), 32'd0);
      dif.ioctl_download = 1'b0;
      dif.ioctl_index    = IDX;
      repeat (3) tick();
      check("foreign_writes", 32'(obs_q.size()), 32'd0);

      // Truncated header: no pointer patch
      run_load(16'h0401, 1, 1'b0, 1'b0);

      // Reset in the middle of a stalled write
      rdy_mode = 3;
      obs_q.delete();
      dif.ioctl_download = 1'b1;
      repeat (2) tick();
      send_byte(25'd0, 8'h00, 1'b0, 1'b0);
      send_byte(25'd1, 8'h10, 1'b0, 1'b0);
      send_byte(25'd2, 8'h5A, 1'b1, 1'b1);
      repeat (2) tick();
      check("stalled_we", 32'(dif.dma_we), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_we",   32'(dif.dma_we),     32'd0);
      check("midrst_busy", 32'(dif.busy),       32'd0);
      check("midrst_wait", 32'(dif.ioctl_wait), 32'd0);
      check("midrst_addr", 32'(dif.dma_addr),   32'd0);
      dif.ioctl_download = 1'b0;
      rdy_mode = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (10) tick();
      check("no_we_after_rst", 32'(obs_q.size()), 32'd0);
      data_q = '{8'hAA, 8'hBB};
      run_load(16'h0401, 2, 1'b0, 1'b0);

      // Randomized loads with stray foreign-index strobes and random RAM readiness
      for (int it = 0; it < 10; it++) begin
         logic [15:0] la;
         int          len;
         case ($urandom_range(0, 2))
            0:       la = 16'($urandom_range(0, 16'hFFFF));
            1:       la = 16'h7FF8 + 16'($urandom_range(0, 15));
            default: la = 16'($urandom_range(16'h0400, 16'h1000));
         endcase
         len = $urandom_range(0, 5);
         data_q.delete();
         for (int j = 0; j < len; j++) data_q.push_back(8'($urandom_range(0, 255)));
         rdy_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
         run_load(la, 2, len > 0 && $urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0);
      end

      check("stable_during_stall", 32'(unstable),  32'd0);
      check("we_while_idle",       32'(we_idle),   32'd0);
      check("wait_during_write",   32'(wait_drop), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prg_loader.md
PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 Parameter INDEX, default 8'h41, ioctl_index value selecting a PRG download.
REQ-002 Parameter RAM_TOP, default 15'h7FFF, highest writable RAM address.
REQ-003 Parameter FIXUP, default 1, enables BASIC pointer patch after load.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ioctl_download  in  1  download window active.
REQ-007 ioctl_index  in  8  download file index.
REQ-008 ioctl_wr  in  1  one-cycle strobe, ioctl_dout/ioctl_addr valid.
REQ-009 ioctl_addr  in  25  byte offset within file.
REQ-010 ioctl_dout  in  8  file byte.
REQ-011 ioctl_wait  out  1  stalls HPS byte stream while high.
REQ-012 dma_addr  out  15  PET RAM write address.
REQ-013 dma_dout  out  8  PET RAM write data.
REQ-014 dma_we  out  1  write request, held until accepted.
REQ-015 dma_rdy  in  1  RAM accepts write in a cycle where dma_we & dma_rdy.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 overflow  out  1  sticky: data byte dropped above RAM_TOP; cleared on next load start.

Function
REQ-018 States: IDLE, HDR_LO, HDR_HI, DATA, WRITE, FIXUP, DONE.
REQ-019 IDLE -> HDR_LO on rising edge of (ioctl_download & ioctl_index==INDEX); overflow cleared, byte count zeroed.
REQ-020 HDR_LO: ioctl_wr with ioctl_addr==0 latches load address [7:0]; -> HDR_HI.
REQ-021 HDR_HI: ioctl_wr with ioctl_addr==1 latches load address [15:8]; -> DATA; cur_addr = load address.
REQ-022 DATA: ioctl_wr with ioctl_addr>1 latches byte, asserts ioctl_wait same cycle (combinational on strobe, then registered), -> WRITE.
REQ-023 WRITE: dma_addr=cur_addr[14:0], dma_dout=latched byte, dma_we=1 until dma_rdy; on accept cur_addr+1 (16-bit), ioctl_wait drops next cycle, -> DATA.
REQ-024 Byte with cur_addr>RAM_TOP (16-bit compare): no dma_we, overflow<=1, cur_addr still increments, ioctl_wait released after one cycle.
REQ-025 cur_addr wrap 16'hFFFF->0: overflow stays set; no writes resume (wrapped flag sticky per load).
REQ-026 ioctl_wr with ioctl_index!=INDEX ignored in all states.
REQ-027 Falling ioctl_download in DATA/HDR states: -> FIXUP if FIXUP=1 and header complete, else DONE; falling edge in WRITE completes pending write first.
REQ-028 FIXUP: end = min(cur_addr, RAM_TOP+1); writes end[7:0], end[15:8] sequentially to 16'h002A,2B,2C,2D,2E,2F, each via dma_we/dma_rdy handshake, one byte per accept; -> DONE.
REQ-029 DONE: one cycle, -> IDLE.
REQ-030 ioctl_wait low in IDLE, FIXUP, DONE.
REQ-031 dma_we never asserted outside WRITE and FIXUP.
REQ-032 New download start while busy ignored until IDLE.

Reset
REQ-033 reset_n low: state IDLE, ioctl_wait=0, dma_we=0, dma_addr=0, dma_dout=0, busy=0, overflow=0, cur_addr=0, immediately (asynchronous).
REQ-034 Reset mid-WRITE abandons the write; no dma_we after release until a new download starts.

Verification
REQ-035 PRG bytes 01 04 AA BB, dma_rdy=1, FIXUP=1 -> writes 0401=AA, 0402=BB, then 002A=03,002B=04,002C=03,002D=04,002E=03,002F=04; busy low after DONE.
REQ-036 Same file, dma_rdy low 5 cycles per write -> dma_we/addr/data stable throughout, ioctl_wait high until accept, no byte lost.
REQ-037 Header FE 7F, data 11 22 33 -> 7FFE=11, 7FFF=22, 33 dropped, overflow=1, fixup end=8000.
REQ-038 Download with index 8'h01 -> no dma_we, ioctl_wait=0, busy=0.
REQ-039 reset_n pulsed low during WRITE -> dma_we=0 same cycle, state IDLE; subsequent full load completes normally with overflow=0.
REQ-040 Download ends after only byte 0 -> no FIXUP writes, DONE then IDLE.
